vend_ctrl_multi: RTL and testbench
==================================

VEND_CTRL_MULTI -- requirements
Module: vend_ctrl_multi

Interface
REQ-001 SHALL have parameter N_ITEMS, default 4: number of products, range 2..8.
REQ-002 SHALL have parameter BAL_W, default 6: balance width in rupees (max 2^BAL_W-1).
REQ-003 SHALL have parameter STOCK_W, default 3: per-item stock counter width.
REQ-004 SHALL have parameter PRICES, default {12,10,7,5}: packed N_ITEMS x BAL_W table, item 0 in LSBs; every price 1..2^BAL_W-1.
REQ-005 SHALL have parameter INIT_STOCK, default 2: stock loaded into every item at reset and on restock.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 16: idle cycles in COLLECT before auto-refund, 2..2^16-1.
REQ-007 SHALL have ports: clk in 1 (system clock); reset in 1 (asynchronous, active-low).
REQ-008 SHALL have ports: coin in 2 (00 none, 01 Rs.1, 10 Rs.2, 11 Rs.5, one coin per cycle); select in clog2(N_ITEMS) (item index, sampled with vend).
REQ-009 SHALL have ports: vend in 1 (purchase request pulse); cancel in 1 (refund request pulse); restock in 1 (reload stock pulse).
REQ-010 SHALL have ports: dispense out 1 (1-cycle pulse); item_out out clog2(N_ITEMS) (item dispensed, valid with dispense).
REQ-011 SHALL have ports: change_coin out 2 (coin paid out this cycle, same encoding as coin, 00 none); coin_reject out 1 (input coin returned this cycle).
REQ-012 SHALL have ports: balance out BAL_W (credit held); busy out 1; sold_out out N_ITEMS (bit i = stock[i]==0); err out 1 (1-cycle pulse on refused vend).

Function
REQ-013 SHALL implement states IDLE (balance 0), COLLECT (balance>0), VEND, PAYOUT; all outputs registered.
REQ-014 SHALL, in IDLE/COLLECT, add an accepted coin to balance on the next edge and enter/stay COLLECT.
REQ-015 SHALL reject a coin (coin_reject=1 next cycle, balance unchanged) when balance+value exceeds 2^BAL_W-1 or state is VEND/PAYOUT.
REQ-016 SHALL, in COLLECT, accept vend at cycle T only if balance>=PRICES[select] and stock[select]>0: cycle T+1 state VEND, dispense=1, item_out=select, balance-=price, stock[select]-=1, busy=1.
REQ-017 SHALL, on vend with insufficient balance or empty stock, pulse err at T+1 and keep balance and state; a select >= N_ITEMS is also refused with err.
REQ-018 SHALL enter PAYOUT from VEND when remaining balance>0, else IDLE.
REQ-019 SHALL, in PAYOUT, issue one change coin per cycle, greedy largest (5, then 2, then 1) not exceeding balance, decrementing balance by it in the same cycle, returning to IDLE after the coin that zeroes balance; busy=1 throughout.
REQ-020 SHALL treat cancel in COLLECT as a refund: enter PAYOUT next cycle, no dispense, stock unchanged; cancel in IDLE/VEND/PAYOUT is ignored.
REQ-021 SHALL give cancel priority over vend when both assert in the same cycle; a coin in that cycle is rejected.
REQ-022 SHALL count idle cycles in COLLECT (no coin/vend/cancel) and, on reaching TIMEOUT_CYC, enter PAYOUT as a refund; any coin, vend or cancel clears the count.
REQ-023 SHALL honour restock only in IDLE (all stocks := INIT_STOCK next cycle); restock elsewhere is ignored.
REQ-024 SHALL keep stock counters saturating at 0; sold_out reflects stock combinationally from registers.

Reset
REQ-025 SHALL, while reset=0, force state IDLE, balance 0, stock[i]=INIT_STOCK, timeout count 0, dispense/change_coin/coin_reject/err/busy 0, item_out 0, independent of clk.
REQ-026 SHALL discard any in-progress vend or payout when reset asserts mid-operation; the first coin after reset release is accepted normally.

Verification
REQ-027 SHALL cover: coins 2,2,1, select=3 (Rs.5), vend -> dispense 1 cycle, item_out=3, no change_coin, balance 0, stock[3]=1.
REQ-028 SHALL cover: coins 5,5, select=2 (Rs.7), vend -> dispense, then change_coin 10 then 01 on consecutive cycles, balance 0, busy low after.
REQ-029 SHALL cover: coins 2,1 then cancel -> change_coin 10 then 01, no dispense, stock unchanged; same cycle cancel+vend -> refund only.
REQ-030 SHALL cover: buy item 3 twice (stock 0, sold_out[3]=1), then coins 5, vend item 3 -> err pulse, balance 5 retained; restock in IDLE -> sold_out=0.
REQ-031 SHALL cover: coin 5 then TIMEOUT_CYC idle cycles -> change_coin 11, balance 0; and coin at balance 60 of Rs.5 -> coin_reject, balance 60.
REQ-032 SHALL cover: reset=0 during PAYOUT -> balance 0, change_coin 00, busy 0 immediately, stocks INIT_STOCK.

Source files
------------

// File: rtl/vend_ctrl_multi_if.sv
// Vending controller bus: customer inputs, dispense/change outputs.
// The master drives coins and requests; the slave reports back.
interface vend_ctrl_multi_if #(
  parameter int N_ITEMS = 4,
  parameter int BAL_W   = 6
);
  localparam int SEL_W = $clog2(N_ITEMS);

  logic [1:0]         coin;
  logic [SEL_W-1:0]   select;
  logic               vend;
  logic               cancel;
  logic               restock;
  logic               dispense;
  logic [SEL_W-1:0]   item_out;
  logic [1:0]         change_coin;
  logic               coin_reject;
  logic [BAL_W-1:0]   balance;
  logic               busy;
  logic [N_ITEMS-1:0] sold_out;
  logic               err;

  modport master (
    output coin, select, vend, cancel, restock,
    input  dispense, item_out, change_coin,
    input  coin_reject, balance, busy, sold_out, err
  );

  modport slave (
    input  coin, select, vend, cancel, restock,
    output dispense, item_out, change_coin,
    output coin_reject, balance, busy, sold_out, err
  );
endinterface

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin credit, per-item stock,
// greedy change payout (5/2/1) and idle-timeout refund.
module vend_ctrl_multi #(
  parameter int N_ITEMS     = 4,
  parameter int BAL_W       = 6,
  parameter int STOCK_W     = 3,
  parameter logic [N_ITEMS*BAL_W-1:0] PRICES =
    {6'd5, 6'd7, 6'd10, 6'd12},
  parameter int INIT_STOCK  = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input logic clk,
  input logic reset,
  vend_ctrl_multi_if.slave bus
);
  localparam int SEL_W = $clog2(N_ITEMS);
  localparam int BW1   = BAL_W + 1;
  localparam logic [BW1-1:0] BAL_MAX =
    BW1'((1 << BAL_W) - 1);
  localparam logic [STOCK_W-1:0] STK0 =
    STOCK_W'(INIT_STOCK);
  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE, COLLECT, VEND, PAYOUT
  } state_t;

  state_t             r_state, w_state_n;
  logic [BAL_W-1:0]   r_bal, w_bal_n;
  logic [15:0]        r_tcnt, w_tcnt_n;
  logic [STOCK_W-1:0] r_stock [N_ITEMS];
  logic               r_disp, w_disp_n;
  logic [SEL_W-1:0]   r_item;
  logic [1:0]         r_chg, w_chg_n;
  logic               r_rej, w_rej_n;
  logic               r_err, w_err_n;
  logic               r_busy;
  logic               w_take, w_restock;
  logic [BAL_W-1:0]   w_price;
  logic [STOCK_W-1:0] w_stk_sel;
  logic [BW1-1:0]     w_sum;
  logic               w_ovf, w_can_buy;
  logic [1:0]         w_pay;
  logic [BAL_W-1:0]   w_bal_pay;
  logic [N_ITEMS-1:0] w_sold;

  function automatic logic [2:0] coin_val(
    input logic [1:0] c
  );
    unique case (c)
      2'b01:   return 3'd1;
      2'b10:   return 3'd2;
      2'b11:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] greedy(
    input logic [BAL_W-1:0] b
  );
    if (b >= BAL_W'(5))      return 2'b11;
    else if (b >= BAL_W'(2)) return 2'b10;
    else if (b != '0)        return 2'b01;
    else                     return 2'b00;
  endfunction

  // Out-of-range select matches nothing: stock 0 forces a refusal.
  always_comb begin
    w_price   = '0;
    w_stk_sel = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (bus.select == SEL_W'(i)) begin
        w_price   = PRICES[i*BAL_W +: BAL_W];
        w_stk_sel = r_stock[i];
      end
    end
  end

  assign w_sum = {1'b0, r_bal}
               + BW1'(coin_val(bus.coin));
  assign w_ovf = w_sum > BAL_MAX;
  assign w_can_buy = (r_bal >= w_price)
                   && (w_stk_sel != '0);
  assign w_pay = greedy(r_bal);
  assign w_bal_pay = r_bal - BAL_W'(coin_val(w_pay));

  always_comb begin
    w_state_n = r_state;
    w_bal_n   = r_bal;
    w_tcnt_n  = r_tcnt;
    w_disp_n  = 1'b0;
    w_chg_n   = 2'b00;
    w_rej_n   = bus.coin != 2'b00;
    w_err_n   = 1'b0;
    w_take    = 1'b0;
    w_restock = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_tcnt_n  = '0;
        w_restock = bus.restock;
        if (bus.vend) begin
          w_err_n = 1'b1;
        end else if (bus.coin != 2'b00 && !w_ovf) begin
          w_bal_n   = w_sum[BAL_W-1:0];
          w_state_n = COLLECT;
          w_rej_n   = 1'b0;
        end
      end
      COLLECT: begin
        w_tcnt_n = '0;
        if (bus.cancel) begin
          w_state_n = PAYOUT;
          w_chg_n   = w_pay;
          w_bal_n   = w_bal_pay;
        end else if (bus.vend) begin
          if (w_can_buy) begin
            w_state_n = VEND;
            w_disp_n  = 1'b1;
            w_bal_n   = r_bal - w_price;
            w_take    = 1'b1;
          end else begin
            w_err_n = 1'b1;
          end
        end else if (bus.coin != 2'b00) begin
          if (!w_ovf) begin
            w_bal_n = w_sum[BAL_W-1:0];
            w_rej_n = 1'b0;
          end
        end else if (r_tcnt == TO_LAST) begin
          w_state_n = PAYOUT;
          w_chg_n   = w_pay;
          w_bal_n   = w_bal_pay;
        end else begin
          w_tcnt_n = r_tcnt + 16'd1;
        end
      end
      VEND: begin
        w_tcnt_n = '0;
        if (r_bal != '0) begin
          w_state_n = PAYOUT;
          w_chg_n   = w_pay;
          w_bal_n   = w_bal_pay;
        end else begin
          w_state_n = IDLE;
        end
      end
      PAYOUT: begin
        w_tcnt_n = '0;
        // The coin that zeroes balance is shown while still in PAYOUT.
        if (r_bal == '0) begin
          w_state_n = IDLE;
        end else begin
          w_chg_n = w_pay;
          w_bal_n = w_bal_pay;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_bal   <= '0;
      r_tcnt  <= '0;
      r_disp  <= 1'b0;
      r_item  <= '0;
      r_chg   <= 2'b00;
      r_rej   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_bal   <= w_bal_n;
      r_tcnt  <= w_tcnt_n;
      r_disp  <= w_disp_n;
      r_chg   <= w_chg_n;
      r_rej   <= w_rej_n;
      r_err   <= w_err_n;
      r_busy  <= (w_state_n == VEND)
              || (w_state_n == PAYOUT);
      if (w_take) r_item <= bus.select;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ITEMS; i++)
        r_stock[i] <= STK0;
    end else begin
      for (int i = 0; i < N_ITEMS; i++) begin
        if (w_restock)
          r_stock[i] <= STK0;
        else if (w_take && bus.select == SEL_W'(i)
                 && r_stock[i] != '0)
          r_stock[i] <= r_stock[i] - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    w_sold = '0;
    for (int i = 0; i < N_ITEMS; i++)
      w_sold[i] = r_stock[i] == '0;
  end

  assign bus.dispense    = r_disp;
  assign bus.item_out    = r_item;
  assign bus.change_coin = r_chg;
  assign bus.coin_reject = r_rej;
  assign bus.balance     = r_bal;
  assign bus.busy        = r_busy;
  assign bus.sold_out    = w_sold;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: purchases, change, refunds,
// sold-out, timeout, overflow and mid-payout reset.
module tb_vend_ctrl_multi;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  vend_ctrl_multi_if #(.N_ITEMS(4), .BAL_W(6)) vif();

  vend_ctrl_multi dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    vif.coin = 2'b00;
    vif.vend = 1'b0;
    vif.cancel = 1'b0;
    vif.restock = 1'b0;
  endtask

  task automatic put(input logic [1:0] c);
    vif.coin = c;
    step();
    vif.coin = 2'b00;
  endtask

  function automatic int cval(input logic [1:0] c);
    return (c == 2'b11) ? 5 : int'(c);
  endfunction

  task automatic test_reset();
    quiet();
    vif.select = 2'd0;
    reset = 1'b0;
    #12;
    total++; if (vif.balance !== 6'd0) begin bad++; $display("FAIL rst_bal got=%0d exp=0", vif.balance); end
    total++; if (vif.busy !== 1'b0 || vif.dispense !== 1'b0) begin bad++; $display("FAIL rst_busy_disp got=%b%b exp=00", vif.busy, vif.dispense); end
    total++; if (vif.sold_out !== 4'b0000 || vif.change_coin !== 2'b00) begin bad++; $display("FAIL rst_sold_chg got=%b/%b exp=0000/00", vif.sold_out, vif.change_coin); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_buy_exact();
    put(2'b10);
    total++; if (vif.balance !== 6'd2) begin bad++; $display("FAIL exact_b1 got=%0d exp=2", vif.balance); end
    put(2'b10);
    put(2'b01);
    total++; if (vif.balance !== 6'd5) begin bad++; $display("FAIL exact_b3 got=%0d exp=5", vif.balance); end
    vif.select = 2'd3; vif.vend = 1'b1;
    step(); vif.vend = 1'b0;
    total++; if (vif.dispense !== 1'b1 || vif.item_out !== 2'd3) begin bad++; $display("FAIL exact_disp got=%b/%0d exp=1/3", vif.dispense, vif.item_out); end
    total++; if (vif.balance !== 6'd0 || vif.busy !== 1'b1) begin bad++; $display("FAIL exact_bal_busy got=%0d/%b exp=0/1", vif.balance, vif.busy); end
    step();
    total++; if (vif.dispense !== 1'b0 || vif.change_coin !== 2'b00 || vif.busy !== 1'b0) begin bad++; $display("FAIL exact_after got=%b/%b/%b exp=0/00/0", vif.dispense, vif.change_coin, vif.busy); end
  endtask

  task automatic test_change();
    put(2'b11);
    put(2'b11);
    vif.select = 2'd2; vif.vend = 1'b1;
    step(); vif.vend = 1'b0;
    total++; if (vif.dispense !== 1'b1 || vif.balance !== 6'd3) begin bad++; $display("FAIL chg_disp got=%b/%0d exp=1/3", vif.dispense, vif.balance); end
    step();
    total++; if (vif.change_coin !== 2'b10 || vif.balance !== 6'd1) begin bad++; $display("FAIL chg_c1 got=%b/%0d exp=10/1", vif.change_coin, vif.balance); end
    step();
    total++; if (vif.change_coin !== 2'b01 || vif.balance !== 6'd0 || vif.busy !== 1'b1) begin bad++; $display("FAIL chg_c2 got=%b/%0d/%b exp=01/0/1", vif.change_coin, vif.balance, vif.busy); end
    step();
    total++; if (vif.change_coin !== 2'b00 || vif.busy !== 1'b0) begin bad++; $display("FAIL chg_end got=%b/%b exp=00/0", vif.change_coin, vif.busy); end
  endtask

  task automatic test_cancel();
    put(2'b10);
    put(2'b01);
    vif.cancel = 1'b1;
    step(); vif.cancel = 1'b0;
    total++; if (vif.change_coin !== 2'b10 || vif.dispense !== 1'b0 || vif.balance !== 6'd1) begin bad++; $display("FAIL can_c1 got=%b/%b/%0d exp=10/0/1", vif.change_coin, vif.dispense, vif.balance); end
    step();
    total++; if (vif.change_coin !== 2'b01 || vif.balance !== 6'd0) begin bad++; $display("FAIL can_c2 got=%b/%0d exp=01/0", vif.change_coin, vif.balance); end
    step();
    total++; if (vif.busy !== 1'b0) begin bad++; $display("FAIL can_idle got=%b exp=0", vif.busy); end
    put(2'b10);
    vif.cancel = 1'b1; vif.vend = 1'b1;
    vif.select = 2'd3; vif.coin = 2'b11;
    step(); quiet();
    total++; if (vif.change_coin !== 2'b10 || vif.dispense !== 1'b0 || vif.err !== 1'b0) begin bad++; $display("FAIL cv_refund got=%b/%b/%b exp=10/0/0", vif.change_coin, vif.dispense, vif.err); end
    total++; if (vif.coin_reject !== 1'b1 || vif.balance !== 6'd0) begin bad++; $display("FAIL cv_rej got=%b/%0d exp=1/0", vif.coin_reject, vif.balance); end
    step();
    total++; if (vif.busy !== 1'b0 || vif.dispense !== 1'b0) begin bad++; $display("FAIL cv_end got=%b/%b exp=0/0", vif.busy, vif.dispense); end
  endtask

  task automatic test_sold_out();
    total++; if (vif.sold_out !== 4'b0000) begin bad++; $display("FAIL so_pre got=%b exp=0000", vif.sold_out); end
    put(2'b11);
    vif.select = 2'd3; vif.vend = 1'b1;
    step(); vif.vend = 1'b0;
    total++; if (vif.dispense !== 1'b1 || vif.sold_out !== 4'b1000) begin bad++; $display("FAIL so_last got=%b/%b exp=1/1000", vif.dispense, vif.sold_out); end
    step();
    put(2'b11);
    vif.vend = 1'b1;
    step(); vif.vend = 1'b0;
    total++; if (vif.err !== 1'b1 || vif.balance !== 6'd5 || vif.dispense !== 1'b0) begin bad++; $display("FAIL so_err got=%b/%0d/%b exp=1/5/0", vif.err, vif.balance, vif.dispense); end
    step();
    total++; if (vif.err !== 1'b0) begin bad++; $display("FAIL so_errpulse got=%b exp=0", vif.err); end
    vif.restock = 1'b1;
    step(); vif.restock = 1'b0;
    total++; if (vif.sold_out !== 4'b1000) begin bad++; $display("FAIL so_rs_ign got=%b exp=1000", vif.sold_out); end
    vif.cancel = 1'b1;
    step(); vif.cancel = 1'b0;
    total++; if (vif.change_coin !== 2'b11 || vif.balance !== 6'd0) begin bad++; $display("FAIL so_ref got=%b/%0d exp=11/0", vif.change_coin, vif.balance); end
    step();
    vif.restock = 1'b1;
    step(); vif.restock = 1'b0;
    total++; if (vif.sold_out !== 4'b0000) begin bad++; $display("FAIL so_restock got=%b exp=0000", vif.sold_out); end
  endtask

  task automatic test_timeout();
    put(2'b11);
    for (int i = 0; i < 15; i++) begin
      step();
      total++; if (vif.change_coin !== 2'b00 || vif.balance !== 6'd5) begin bad++; $display("FAIL to_early%0d got=%b/%0d exp=00/5", i, vif.change_coin, vif.balance); end
    end
    step();
    total++; if (vif.change_coin !== 2'b11 || vif.balance !== 6'd0) begin bad++; $display("FAIL to_fire got=%b/%0d exp=11/0", vif.change_coin, vif.balance); end
    step();
    total++; if (vif.busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%b exp=0", vif.busy); end
  endtask

  task automatic test_overflow();
    int sum;
    for (int i = 0; i < 12; i++) put(2'b11);
    total++; if (vif.balance !== 6'd60) begin bad++; $display("FAIL ov_60 got=%0d exp=60", vif.balance); end
    put(2'b11);
    total++; if (vif.coin_reject !== 1'b1 || vif.balance !== 6'd60) begin bad++; $display("FAIL ov_rej5 got=%b/%0d exp=1/60", vif.coin_reject, vif.balance); end
    put(2'b10);
    total++; if (vif.coin_reject !== 1'b0 || vif.balance !== 6'd62) begin bad++; $display("FAIL ov_62 got=%b/%0d exp=0/62", vif.coin_reject, vif.balance); end
    put(2'b10);
    total++; if (vif.coin_reject !== 1'b1 || vif.balance !== 6'd62) begin bad++; $display("FAIL ov_rej2 got=%b/%0d exp=1/62", vif.coin_reject, vif.balance); end
    put(2'b01);
    total++; if (vif.balance !== 6'd63) begin bad++; $display("FAIL ov_63 got=%0d exp=63", vif.balance); end
    vif.cancel = 1'b1;
    step(); vif.cancel = 1'b0;
    sum = cval(vif.change_coin);
    for (int i = 0; i < 30; i++) begin
      if (vif.busy !== 1'b1) break;
      step();
      sum += cval(vif.change_coin);
    end
    total++; if (sum != 63 || vif.busy !== 1'b0) begin bad++; $display("FAIL ov_refund got=%0d/%b exp=63/0", sum, vif.busy); end
  endtask

  task automatic test_reset_mid();
    put(2'b11);
    vif.select = 2'd3; vif.vend = 1'b1;
    step(); vif.vend = 1'b0;
    step();
    put(2'b11);
    put(2'b11);
    vif.cancel = 1'b1;
    step(); vif.cancel = 1'b0;
    total++; if (vif.busy !== 1'b1 || vif.change_coin !== 2'b11) begin bad++; $display("FAIL rm_pay got=%b/%b exp=1/11", vif.busy, vif.change_coin); end
    #2 reset = 1'b0;
    #1;
    total++; if (vif.balance !== 6'd0 || vif.change_coin !== 2'b00 || vif.busy !== 1'b0) begin bad++; $display("FAIL rm_async got=%0d/%b/%b exp=0/00/0", vif.balance, vif.change_coin, vif.busy); end
    #3 reset = 1'b1;
    step();
    put(2'b11);
    total++; if (vif.balance !== 6'd5 || vif.coin_reject !== 1'b0) begin bad++; $display("FAIL rm_coin got=%0d/%b exp=5/0", vif.balance, vif.coin_reject); end
    vif.vend = 1'b1;
    step(); vif.vend = 1'b0;
    total++; if (vif.sold_out !== 4'b0000 || vif.dispense !== 1'b1) begin bad++; $display("FAIL rm_stock got=%b/%b exp=0000/1", vif.sold_out, vif.dispense); end
    step();
    put(2'b11);
    vif.vend = 1'b1;
    step(); vif.vend = 1'b0;
    total++; if (vif.sold_out !== 4'b1000 || vif.dispense !== 1'b1) begin bad++; $display("FAIL rm_stock2 got=%b/%b exp=1000/1", vif.sold_out, vif.dispense); end
    step();
  endtask

  initial begin
    test_reset();
    test_buy_exact();
    test_change();
    test_cancel();
    test_sold_out();
    test_timeout();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
